ps2_keyboard: RTL and testbench
===============================

# ps2_keyboard

PS/2 keyboard receiver and scan-code translator that produces the Hack keyboard word. It sits upstream of the data memory's keyboard register at address 24576: it samples the board's PS/2 clock/data pins and decodes scan-code set 2 frames. It drives a 16-bit Hack key code while a key is held and 0 when no key is held, so the CPU reads it with a plain load.

## Interface
- FILTER_LEN, 4: number of consecutive identical synchronized samples required before the filtered PS/2 clock changes state (≥2).
- TIMEOUT_CYCLES, 200000: idle `clk` cycles mid-frame after which a partial frame is discarded (2 ms at 100 MHz).

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous, idle high).
- ps2_data  in  1  raw PS/2 data pin (asynchronous, idle high).
- key_out  out  16  Hack key code of the currently held key; 0 = none.
- frame_error  out  1  one-cycle pulse when a frame is rejected (start, parity, stop or timeout).

## Operation
- Input conditioning: both pins pass through a 2-flop synchronizer. ps2_clk then passes through a FILTER_LEN shift register; the filtered clock flips only when all samples agree. A "fall" is a cycle in which the filtered clock goes 1→0.
- Frame FSM, IDLE / RECV:
  - IDLE: on a fall with data=0 (start bit), go to RECV with bit_cnt=0. A fall with data=1 pulses frame_error and stays in IDLE.
  - RECV: each fall shifts data in. Bits 0–7 are data (LSB first), bit 8 is parity, bit 9 is stop.
  - On the stop-bit fall, the frame is accepted only if parity over data+parity is odd and stop=1. Otherwise frame_error pulses and the byte is dropped. Either way, return to IDLE.
  - Timeout counter clears on every fall. If it reaches TIMEOUT_CYCLES in RECV, frame_error pulses and the FSM returns to IDLE.
- Decoder on each accepted byte. Flags `ext` (E0 seen) and `brk` (F0 seen) are held:
  - E0 sets ext. F0 sets brk. Any other byte is a code: map it using ext, then clear both flags.
  - Make code with a nonzero mapping sets key_out to the mapped value. Typematic repeats rewrite the same value.
  - Break code sets key_out to 0 only if its mapping equals the current key_out. Releasing a non-current key leaves key_out unchanged.
  - Unmapped codes are ignored; flags still clear.
  - A rejected frame clears ext and brk.
- Mapping, non-extended:
  - Letters → uppercase ASCII: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29→32 (space), 5A→128, 66→129, 76→140.
- Mapping, extended: 6B→130, 75→131, 74→132, 72→133, 6C→134, 69→135, 7D→136, 7A→137, 70→138, 71→139. All other extended codes are unmapped.
- Reset clears synchronizers (to 1), the filter (to 1), the FSM (to IDLE), counters, ext and brk. It drives key_out=0 and frame_error=0. Reset mid-frame discards the partial frame with no error pulse.

## Timing
- Fall detect latency: FILTER_LEN+2 cycles after a raw ps2_clk falling edge (data sampled through the same sync depth).
- key_out updates on the clock edge following the stop-bit fall cycle. frame_error asserts in that same cycle for a bad frame, and lasts exactly 1 cycle.
- ps2_clk pulses shorter than FILTER_LEN cycles produce no fall.
- No handshake: key_out is level-valid at all times. The design does not drive the PS/2 lines (host-to-device unsupported).

## Test plan
Bench uses FILTER_LEN=4, TIMEOUT_CYCLES=1000, PS/2 bit period 200 cycles, data changed mid-high.
- Reset held 3 cycles while ps2_clk toggles → key_out=0x0000, frame_error=0 throughout.
- Frames 1C; then F0 1C → key_out=0x0041 after the first stop bit; 0x0000 after the second 1C.
- E0 6B; then E0 F0 6B → key_out=130; then 0. Also 6B alone (no E0) → key_out unchanged.
- 1C, 32, F0 1C, F0 32 → key_out 65, 66, 66 (A release ignored), 0.
- 0x1C frame with even parity → frame_error high 1 cycle, key_out stays 0. A following good 0x29 → key_out=32.
- Send start+4 bits, stall 1200 cycles → one frame_error pulse. Then a full 0x5A frame with a 2-cycle glitch low on ps2_clk mid-bit → key_out=128, no error.

Source files
------------

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 set-2 receiver that presents the held key as a Hack keyboard word.
module ps2_keyboard #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_out,
    output logic        frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {IDLE, RECV} state_t;
    logic [1:0]            clk_s_q, dat_s_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q, fclk_d, fall, din;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [8:0]            sh_q, sh_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  ext_q, ext_d, brk_q, brk_d, err_q, err_d;
    logic [15:0]           key_q, key_d, code;

    function automatic logic [15:0] map(input logic e, input logic [7:0] c);
        if (e) begin
            case (c)
                8'h6B: return 16'd130;
                8'h75: return 16'd131;
                8'h74: return 16'd132;
                8'h72: return 16'd133;
                8'h6C: return 16'd134;
                8'h69: return 16'd135;
                8'h7D: return 16'd136;
                8'h7A: return 16'd137;
                8'h70: return 16'd138;
                8'h71: return 16'd139;
                default: return 16'd0;
            endcase
        end
        case (c)
            8'h1C: return 16'd65;
            8'h32: return 16'd66;
            8'h21: return 16'd67;
            8'h23: return 16'd68;
            8'h24: return 16'd69;
            8'h2B: return 16'd70;
            8'h34: return 16'd71;
            8'h33: return 16'd72;
            8'h43: return 16'd73;
            8'h3B: return 16'd74;
            8'h42: return 16'd75;
            8'h4B: return 16'd76;
            8'h3A: return 16'd77;
            8'h31: return 16'd78;
            8'h44: return 16'd79;
            8'h4D: return 16'd80;
            8'h15: return 16'd81;
            8'h2D: return 16'd82;
            8'h1B: return 16'd83;
            8'h2C: return 16'd84;
            8'h3C: return 16'd85;
            8'h2A: return 16'd86;
            8'h1D: return 16'd87;
            8'h22: return 16'd88;
            8'h35: return 16'd89;
            8'h1A: return 16'd90;
            8'h45: return 16'd48;
            8'h16: return 16'd49;
            8'h1E: return 16'd50;
            8'h26: return 16'd51;
            8'h25: return 16'd52;
            8'h2E: return 16'd53;
            8'h36: return 16'd54;
            8'h3D: return 16'd55;
            8'h3E: return 16'd56;
            8'h46: return 16'd57;
            8'h29: return 16'd32;
            8'h5A: return 16'd128;
            8'h66: return 16'd129;
            8'h76: return 16'd140;
            default: return 16'd0;
        endcase
    endfunction

    // Filtered clock only moves once every sample in the window agrees.
    assign fclk_d = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : fclk_q;
    assign fall   = fclk_q & ~fclk_d;
    assign din    = dat_s_q[1];
    assign code   = map(ext_q, sh_q[7:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tmr_d   = (fall || state_q == IDLE) ? '0 : tmr_q + 1'b1;
        ext_d   = ext_q;
        brk_d   = brk_q;
        key_d   = key_q;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (fall && din) begin
                err_d = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (fall) begin
                state_d = RECV;
                cnt_d   = '0;
            end
        end else if (fall && cnt_q != 4'd9) begin
            sh_d  = {din, sh_q[8:1]};
            cnt_d = cnt_q + 4'd1;
        end else if (fall && ^sh_q && din) begin
            state_d = IDLE;
            if (sh_q[7:0] == 8'hE0) ext_d = 1'b1;
            else if (sh_q[7:0] == 8'hF0) brk_d = 1'b1;
            else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                key_d = code == '0 ? key_q : !brk_q ? code : code == key_q ? '0 : key_q;
            end
        end else if (fall || tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s_q <= '1;
            dat_s_q <= '1;
            filt_q  <= '1;
            fclk_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            tmr_q   <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_data};
            filt_q  <= {filt_q[FILTER_LEN-2:0], clk_s_q[1]};
            fclk_q  <= fclk_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tmr_q   <= tmr_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    assign key_out     = key_q;
    assign frame_error = err_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed and random PS/2 frames checked against a table-driven key model.
module tb_ps2_keyboard;
    logic        clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [15:0] key_out;
    logic        frame_error;
    int          checks = 0, errors = 0, err_pulses = 0, exp_err = 0;
    int          nmap[256], emap[256];
    logic [15:0] m_key = '0;
    bit          m_ext = 0, m_brk = 0;

    ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_out(key_out), .frame_error(frame_error)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (frame_error === 1'b1) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        int v;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            v = m_ext ? emap[b] : nmap[b];
            if (v != 0 && !m_brk) m_key = 16'(v);
            else if (v != 0 && m_key == 16'(v)) m_key = '0;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch);
        for (int i = 0; i < n; i++) begin
            repeat (20) @(negedge clk);
            if (glitch == i) begin
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (30) @(negedge clk);
            ps2_data = bits[i];
            repeat (50) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (100) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit good, input int glitch);
        logic [10:0] f;
        f = {1'b1, good ? ~^b : ^b, b, 1'b0};
        send_bits(f, 11, glitch);
        repeat (20) @(negedge clk);
        if (good) m_byte(b);
        else begin
            m_ext = 0;
            m_brk = 0;
            exp_err++;
        end
        chk({tag, "_key"}, 32'(key_out), 32'(m_key));
        chk({tag, "_err"}, 32'(err_pulses), 32'(exp_err));
    endtask

    initial begin
        logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] ec[10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
        logic [7:0] pool[16] = '{8'h1C, 8'h32, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h45, 8'h46,
                                 8'h6B, 8'h75, 8'h71, 8'hE0, 8'hF0, 8'hF0, 8'h0E, 8'h7E};
        for (int i = 0; i < 256; i++) begin
            nmap[i] = 0;
            emap[i] = 0;
        end
        for (int i = 0; i < 26; i++) nmap[lc[i]] = 65 + i;
        for (int i = 0; i < 10; i++) nmap[dc[i]] = 48 + i;
        for (int i = 0; i < 10; i++) emap[ec[i]] = 130 + i;
        nmap[8'h29] = 32;
        nmap[8'h5A] = 128;
        nmap[8'h66] = 129;
        nmap[8'h76] = 140;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ps2_clk = ~ps2_clk;
            chk("rst_key", 32'(key_out), 32'h0);
            chk("rst_err", 32'(frame_error), 32'h0);
        end
        ps2_clk = 1'b1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_key", 32'(key_out), 32'h0);
        chk("post_rst_err", 32'(err_pulses), 32'h0);
        frame("a_make", 8'h1C, 1, -1);
        chk("a_val", 32'(key_out), 32'h41);
        frame("a_f0", 8'hF0, 1, -1);
        frame("a_brk", 8'h1C, 1, -1);
        chk("a_rel", 32'(key_out), 32'h0);
        frame("e0", 8'hE0, 1, -1);
        frame("left", 8'h6B, 1, -1);
        chk("left_val", 32'(key_out), 32'd130);
        frame("e0b", 8'hE0, 1, -1);
        frame("f0b", 8'hF0, 1, -1);
        frame("left_rel", 8'h6B, 1, -1);
        chk("left_zero", 32'(key_out), 32'd0);
        frame("plain6b", 8'h6B, 1, -1);
        frame("a2", 8'h1C, 1, -1);
        frame("b2", 8'h32, 1, -1);
        frame("f0a", 8'hF0, 1, -1);
        frame("a2_rel", 8'h1C, 1, -1);
        chk("b_held", 32'(key_out), 32'd66);
        frame("f0c", 8'hF0, 1, -1);
        frame("b2_rel", 8'h32, 1, -1);
        frame("badpar", 8'h1C, 0, -1);
        chk("badpar_key", 32'(key_out), 32'd0);
        frame("space", 8'h29, 1, -1);
        chk("space_val", 32'(key_out), 32'd32);
        send_bits(11'b100_0110_1010, 5, -1);
        repeat (1200) @(negedge clk);
        exp_err++;
        m_ext = 0;
        m_brk = 0;
        chk("timeout_err", 32'(err_pulses), 32'(exp_err));
        chk("timeout_key", 32'(key_out), 32'(m_key));
        frame("glitch", 8'h5A, 1, 4);
        chk("glitch_val", 32'(key_out), 32'd128);
        for (int i = 0; i < 12; i++) frame("rand", pool[$urandom_range(15)], $urandom_range(7) != 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
